// File: rtl/ua_receiver.sv
// UART 8N1 receiver: oversampled start/data/stop recovery with a valid/ack byte handshake.
// Optional UA_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module ua_receiver #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ser_in,
  output logic [7:0] dout_byte,
  output logic       dout_valid,
  input  logic       dout_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

`ifdef UA_RX_MAJORITY_EN
  // Decision moves to the last vote tick; reloading to 1 keeps the bit period at OVERSAMPLE.
  localparam int unsigned TICK_W   = $clog2(OVERSAMPLE + 1);
  localparam int unsigned START_PT = OVERSAMPLE / 2;
  localparam int unsigned BIT_PT   = OVERSAMPLE;
  localparam int unsigned RELOAD   = 1;
`else
  localparam int unsigned TICK_W   = $clog2(OVERSAMPLE);
  localparam int unsigned START_PT = OVERSAMPLE / 2 - 1;
  localparam int unsigned BIT_PT   = OVERSAMPLE - 1;
  localparam int unsigned RELOAD   = 0;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             dout_byte_q, dout_byte_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   byte_done;
  logic                   rx_s;
  logic                   rx_sample;
  logic [TICK_W-1:0]      sample_pt;
  logic                   at_pt;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign sample_pt = (state_q == START) ? TICK_W'(START_PT) : TICK_W'(BIT_PT);
  assign at_pt     = (tick_q == sample_pt);

`ifdef UA_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  // Collect the two samples preceding the decision tick.
  always_comb begin
    maj_d = maj_q;
    if (enable && ((tick_q == sample_pt - TICK_W'(2)) || (tick_q == sample_pt - TICK_W'(1))))
      maj_d = {maj_q[0], rx_s};
  end

  assign rx_sample = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);

  always_ff @(posedge clk) begin
    if (rst) maj_q <= 2'b11;
    else     maj_q <= maj_d;
  end
`else
  assign rx_sample = rx_s;
`endif

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], ser_in};
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    dout_byte_d  = dout_byte_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
    byte_done    = 1'b0;

    if (dout_valid_q && dout_ack) begin
      dout_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end

    if (enable) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (at_pt) begin
            tick_d = '0;
            if (!rx_sample) begin
              state_d = DATA;
              tick_d  = TICK_W'(RELOAD);
              bit_d   = 3'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        DATA: begin
          if (at_pt) begin
            shift_d = {rx_sample, shift_q[7:1]};
            tick_d  = TICK_W'(RELOAD);
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        STOP: begin
          if (at_pt) begin
            state_d = IDLE;
            tick_d  = '0;
            if (rx_sample) byte_done   = 1'b1;
            else           frame_err_d = 1'b1;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A completing byte beats a same-cycle ack; only an unacked pending byte is an overrun.
    if (byte_done) begin
      dout_byte_d  = shift_q;
      dout_valid_d = 1'b1;
      if (dout_valid_q && !dout_ack) overrun_d = 1'b1;
    end

    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= '1;
      tick_q       <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'h00;
      dout_byte_q  <= 8'h00;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      dout_byte_q  <= dout_byte_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign dout_byte  = dout_byte_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_ua_receiver.sv
// Directed bench for ua_receiver: enable every 4th clk, OVERSAMPLE=16, 64 clk per bit.
module tb_ua_receiver;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable = 1'b0;
  logic       ser_in;
  logic [7:0] dout_byte;
  logic       dout_valid;
  logic       dout_ack;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int fe_wide = 0;
  int unsigned en_cnt = 0;
  logic fe_prev = 1'b0;

  ua_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ser_in(ser_in),
    .dout_byte(dout_byte), .dout_valid(dout_valid), .dout_ack(dout_ack),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      en_cnt = en_cnt + 1;
      enable = (en_cnt % 4 == 0);
    end
  end

  // Counts frame_err pulses and any pulse lasting longer than one clk.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err) fe_cnt = fe_cnt + 1;
      if (frame_err && fe_prev) fe_wide = fe_wide + 1;
      fe_prev = frame_err;
    end
  end

  task automatic drive_bit(input logic v);
    ser_in = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic pulse_ack();
    dout_ack = 1'b1;
    @(negedge clk);
    dout_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (dout_byte !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got %h want 00", dout_byte); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", rx_busy); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic_a5();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    n_cmp++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL a5_valid: got %b want 1", dout_valid); end
    n_cmp++; if (dout_byte !== 8'hA5) begin n_fail++; $display("FAIL a5_byte: got %h want a5", dout_byte); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL a5_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL a5_overrun: got %b want 0", overrun); end
    pulse_ack();
    n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL a5_ack_valid: got %b want 0", dout_valid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL a5_idle_busy: got %b want 0", rx_busy); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1);
    n_cmp++; if (dout_byte !== 8'h3C) begin n_fail++; $display("FAIL b2b_first_byte: got %h want 3c", dout_byte); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_first_overrun: got %b want 0", overrun); end
    send_frame(8'hC3, 1'b1);
    n_cmp++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", dout_valid); end
    n_cmp++; if (dout_byte !== 8'hC3) begin n_fail++; $display("FAIL b2b_byte: got %h want c3", dout_byte); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    pulse_ack();
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_overrun: got %b want 0", overrun); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_valid: got %b want 0", dout_valid); end
    pulse_ack();
    n_cmp++; if (dout_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ack: got valid %b overrun %b want 0 0", dout_valid, overrun); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame_err();
    int fe0;
    int w0;
    fe0 = fe_cnt;
    w0  = fe_wide;
    send_frame(8'h55, 1'b0);
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL fe_pulse_count: got %0d want 1", fe_cnt - fe0); end
    n_cmp++; if (fe_wide - w0 !== 0) begin n_fail++; $display("FAIL fe_pulse_width: got %0d long pulses want 0", fe_wide - w0); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL fe_valid: got %b want 0", dout_valid); end
    n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL fe_retrigger_busy: got %b want 1", rx_busy); end
    ser_in = 1'b1;
    repeat (100) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL fe_release_busy: got %b want 0", rx_busy); end
    n_cmp++; if (dout_valid !== 1'b0 || fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL fe_release_out: got valid %b pulses %0d want 0 1", dout_valid, fe_cnt - fe0); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    ser_in = 1'b0;
    repeat (12) @(negedge clk);
    ser_in = 1'b1;
    n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start_busy: got %b want 1", rx_busy); end
    repeat (60) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_busy: got %b want 0", rx_busy); end
    n_cmp++; if (dout_valid !== 1'b0 || fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_out: got valid %b pulses %0d want 0 0", dout_valid, fe_cnt - fe0); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] part;
    part = 8'h5A;
    send_frame(8'h81, 1'b1);
    n_cmp++; if (dout_valid !== 1'b1 || dout_byte !== 8'h81) begin n_fail++; $display("FAIL mfr_pre: got valid %b byte %h want 1 81", dout_valid, dout_byte); end
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(part[i]);
    ser_in = part[4];
    repeat (32) @(negedge clk);
    rst = 1'b1;
    ser_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (dout_byte !== 8'h00) begin n_fail++; $display("FAIL mfr_byte: got %h want 00", dout_byte); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mfr_valid: got %b want 0", dout_valid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mfr_busy: got %b want 0", rx_busy); end
    n_cmp++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL mfr_flags: got overrun %b frame_err %b want 0 0", overrun, frame_err); end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mfr_lost: got %b want 0", dout_valid); end
    send_frame(8'h0F, 1'b1);
    n_cmp++; if (dout_valid !== 1'b1 || dout_byte !== 8'h0F) begin n_fail++; $display("FAIL mfr_after: got valid %b byte %h want 1 0f", dout_valid, dout_byte); end
    pulse_ack();
    repeat (20) @(negedge clk);
  endtask

  // One enable-tick low glitch at each data-bit centre of 8'hFF.
  task automatic test_majority();
    logic [7:0] exp_byte;
    int fe0;
`ifdef UA_RX_MAJORITY_EN
    exp_byte = 8'hFF;
`else
    exp_byte = 8'h00;
`endif
    fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      ser_in = 1'b1;
      repeat (32) @(negedge clk);
      ser_in = 1'b0;
      repeat (4) @(negedge clk);
      ser_in = 1'b1;
      repeat (28) @(negedge clk);
    end
    drive_bit(1'b1);
    n_cmp++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL maj_valid: got %b want 1", dout_valid); end
    n_cmp++; if (dout_byte !== exp_byte) begin n_fail++; $display("FAIL maj_byte: got %h want %h", dout_byte, exp_byte); end
    n_cmp++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL maj_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    pulse_ack();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    ser_in   = 1'b1;
    dout_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_a5();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_mid_frame_reset();
    test_majority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
